// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and zero-extension helper for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_ORR  = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_BAND = 4'b0011;
  localparam logic [3:0] OP_BOR  = 4'b0100;
  localparam logic [3:0] OP_BXOR = 4'b0101;
  localparam logic [3:0] OP_GT   = 4'b0110;
  localparam logic [3:0] OP_LT   = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1000;
  localparam logic [3:0] OP_EQ   = 4'b1001;
  localparam logic [3:0] OP_ADD  = 4'b1010;
  localparam logic [3:0] OP_SUB  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_INV  = 4'b1101;
  localparam logic [3:0] OP_SHL  = 4'b1110;
  localparam logic [3:0] OP_SHR  = 4'b1111;

  // Widest operand the zero-extension helper supports.
  localparam int MAX_W = 64;

  typedef enum logic [0:0] {IDLE, MUL} state_t;

  // Callers cast the result down to 2*WIDTH bits.
  function automatic logic [2*MAX_W-1:0] zext(input logic [MAX_W-1:0] v);
    return {{MAX_W{1'b0}}, v};
  endfunction

endpackage

// File: rtl/alu_mul_shiftadd.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles after load.
module alu_mul_shiftadd #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  // product already includes the current step, so the top captures it on the last edge.
  assign product = mplier[0] ? acc + mcand : acc;
  assign last    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else begin
      cnt    <= cnt + 1'b1;
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU: single-cycle ops complete on the start edge,
// multiply runs WIDTH cycles through the shift-add unit.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero
);

  localparam int RW = 2 * WIDTH;

  state_t          state;
  logic [RW-1:0]   r_sc;
  logic [RW-1:0]   ext_a;
  logic            carry_sc;
  logic [RW-1:0]   product;
  logic            mul_last;
  logic            mul_load;

  always_comb begin
    ext_a    = RW'(zext(MAX_W'(a)));
    r_sc     = '0;
    carry_sc = 1'b0;
    case (opcode)
      OP_ORR:  r_sc[0] = |a;
      OP_AND:  r_sc[0] = &a;
      OP_XOR:  r_sc[0] = ^a;
      OP_BAND: r_sc[WIDTH-1:0] = a & b;
      OP_BOR:  r_sc[WIDTH-1:0] = a | b;
      OP_BXOR: r_sc[WIDTH-1:0] = a ^ b;
      OP_GT:   r_sc[0] = (a > b);
      OP_LT:   r_sc[0] = (a < b);
      OP_NOT:  r_sc[0] = ~|a;
      OP_EQ:   r_sc[0] = (a == b);
      OP_ADD: begin
        r_sc[WIDTH:0] = {1'b0, a} + {1'b0, b};
        carry_sc      = r_sc[WIDTH];
      end
      OP_SUB: begin
        r_sc[WIDTH-1:0] = a - b;
        carry_sc        = (a < b);
      end
      OP_INV:  r_sc[WIDTH-1:0] = ~a;
      // Oversized shift amounts shift everything out, giving 0.
      OP_SHL:  r_sc = ext_a << b;
      OP_SHR:  r_sc[WIDTH-1:0] = a >> b;
      default: r_sc = '0;
    endcase
  end

  assign mul_load = (state == IDLE) && start && (opcode == OP_MUL);
  assign busy     = (state == MUL);

  alu_mul_shiftadd #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load),
    .a       (a),
    .b       (b),
    .product (product),
    .last    (mul_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (opcode == OP_MUL) begin
            state <= MUL;
          end else begin
            {y, x} <= r_sc;
            carry  <= carry_sc;
            zero   <= (r_sc == '0);
            done   <= 1'b1;
          end
        end
      end else if (mul_last) begin
        {y, x} <= product;
        carry  <= 1'b0;
        zero   <= (product == '0);
        done   <= 1'b1;
        state  <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH=8.
module tb_alu_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic [3:0] opcode;
  logic       busy, done, carry, zero;
  logic [7:0] x, y;

  int total = 0;
  int bad   = 0;
  int nbusy;
  int ndone;
  bit seen;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .opcode (opcode),
    .busy   (busy),
    .done   (done),
    .x      (x),
    .y      (y),
    .carry  (carry),
    .zero   (zero)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one single-cycle op; returns at the negedge after its start edge.
  task automatic op1(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb);
    @(negedge clk);
    start = 1'b1; opcode = op; a = va; b = vb;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Start a multiply; optionally keep pulsing an add while busy. Returns at the done negedge.
  task automatic run_mul(input logic [7:0] ma, input logic [7:0] mb, input bit poke,
                         output int nb, output bit got_done);
    @(negedge clk);
    start = 1'b1; opcode = 4'b1100; a = ma; b = mb;
    @(negedge clk);
    nb = 0; got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      if (done) got_done = 1'b1;
      else begin
        if (busy) nb++;
        start = poke; opcode = 4'b1010; a = 8'h01; b = 8'h01;
        @(negedge clk);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; opcode = '0;
    repeat (2) @(negedge clk);
    chk("rst_out", {busy, done, carry, zero, 4'h0, x}, 16'h0000);
    chk("rst_y", {8'h0, y}, 16'h0000);
    rst = 1'b0;

    op1(4'b1010, 8'hF0, 8'h20);
    chk("add_done", 16'(done), 16'h1);
    chk("add_r", {y, x}, 16'h0110);
    chk("add_cz", {14'h0, carry, zero}, 16'h2);

    op1(4'b1011, 8'h05, 8'h07);
    chk("sub_r", {y, x}, 16'h00FE);
    chk("sub_cz", {14'h0, carry, zero}, 16'h2);
    op1(4'b1011, 8'h33, 8'h33);
    chk("sub0_r", {y, x}, 16'h0000);
    chk("sub0_cz", {14'h0, carry, zero}, 16'h1);

    // Back-to-back starts keep done high.
    @(negedge clk);
    start = 1'b1; opcode = 4'b0101; a = 8'h0F; b = 8'hFF;
    @(negedge clk);
    chk("b2b_done1", 16'(done), 16'h1);
    chk("b2b_x1", {y, x}, 16'h00F0);
    opcode = 4'b0100; a = 8'h12; b = 8'h21;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done2", 16'(done), 16'h1);
    chk("b2b_x2", {y, x}, 16'h0033);
    @(negedge clk);
    chk("hold_done", 16'(done), 16'h0);
    chk("hold_x", {y, x}, 16'h0033);

    run_mul(8'hFF, 8'hFF, 1'b1, nbusy, seen);
    chk("mul_seen", 16'(seen), 16'h1);
    chk("mul_busy_cyc", 16'(nbusy), 16'd8);
    chk("mul_r", {y, x}, 16'hFE01);
    chk("mul_flags", {13'h0, busy, carry, zero}, 16'h0);
    @(negedge clk);
    chk("mul_single_done", 16'(done), 16'h0);
    chk("mul_hold", {y, x}, 16'hFE01);

    op1(4'b1110, 8'h81, 8'd9);
    chk("shl9", {y, x}, 16'h0200);
    op1(4'b1110, 8'h81, 8'd16);
    chk("shl16", {y, x}, 16'h0000);
    chk("shl16_z", 16'(zero), 16'h1);
    op1(4'b1111, 8'h80, 8'd7);
    chk("shr7", {y, x}, 16'h0001);
    op1(4'b1111, 8'h80, 8'd8);
    chk("shr8", {y, x}, 16'h0000);

    op1(4'b0001, 8'hFF, 8'h00);
    chk("and_red", {y, x}, 16'h0001);
    op1(4'b0110, 8'h03, 8'h09);
    chk("gt", {y, x}, 16'h0000);
    op1(4'b0111, 8'h03, 8'h09);
    chk("lt", {y, x}, 16'h0001);
    op1(4'b1001, 8'h5A, 8'h5A);
    chk("eq", {y, x}, 16'h0001);
    op1(4'b1101, 8'h3C, 8'h00);
    chk("inv", {y, x}, 16'h00C3);
    op1(4'b1000, 8'h00, 8'h00);
    chk("not", {y, x}, 16'h0001);

    // Reset four cycles into a multiply.
    @(negedge clk);
    start = 1'b1; opcode = 4'b1100; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 16'(busy), 16'h1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out", {busy, done, carry, zero, 4'h0, x}, 16'h0000);
    chk("async_rst_y", {8'h0, y}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("post_rst_quiet", 16'(ndone), 16'h0);

    run_mul(8'h03, 8'h05, 1'b0, nbusy, seen);
    chk("mul35_seen", 16'(seen), 16'h1);
    chk("mul35_r", {y, x}, 16'h000F);
    // Start accepted in the done cycle.
    start = 1'b1; opcode = 4'b1010; a = 8'h01; b = 8'h02;
    @(negedge clk);
    start = 1'b0;
    chk("after_mul_done", 16'(done), 16'h1);
    chk("after_mul_r", {y, x}, 16'h0003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
